// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand-fetch / issue stage in front of the 32-bit ALU. Holds the
//   architectural register file, reads two sources per instruction and
//   presents A, B, ALUControl and the destination tag through a one-entry
//   valid/ready issue register. Write-back data is bypassed into the read
//   path and into a held (stalled) instruction so the ALU never sees a
//   stale operand.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake for a decoded instruction
//   rs1, rs2, rd, alu_ctrl_in source tags, destination tag, ALU op code
//   flush                     drop the held instruction (wins over capture)
//   wb_en, wb_addr, wb_data   register write-back port
//   out_valid/out_ready       downstream handshake
//   A, B, ALUControl, out_rd  issued operands, op code and destination tag
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [AW-1:0]     rd,
  input  logic [3:0]        alu_ctrl_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALUControl,
  output logic [AW-1:0]     out_rd
);

  logic [DATA_W-1:0] rf_q [NREG];

  logic              vld_q,  vld_d;
  logic [DATA_W-1:0] a_q,    a_d;
  logic [DATA_W-1:0] b_q,    b_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [AW-1:0]     rd_q,   rd_d;
  logic [AW-1:0]     rs1_q,  rs1_d;
  logic [AW-1:0]     rs2_q,  rs2_d;

  logic              capture, consume;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] rdata1, rdata2;

  // Register file: r0 is never written, so it stays at its reset value 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Write-first read: a same-cycle write-back to the source wins over the array.
  always_comb begin
    rdata1 = '0;
    if (rs1 != '0) rdata1 = (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
  end

  always_comb begin
    rdata2 = '0;
    if (rs2 != '0) rdata2 = (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];
  end

  assign in_ready = !vld_q || out_ready;
  // Flush blocks acceptance even though in_ready may read 1.
  assign capture  = in_valid && in_ready && !flush;
  assign consume  = vld_q && out_ready;

  // Write-back hits on the tags of the held instruction.
  assign hit_a = wb_en && (rs1_q != '0) && (wb_addr == rs1_q);
  assign hit_b = wb_en && (rs2_q != '0) && (wb_addr == rs2_q);

  always_comb begin
    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (capture) begin
      vld_d  = 1'b1;
      a_d    = rdata1;
      b_d    = rdata2;
      ctrl_d = alu_ctrl_in;
      rd_d   = rd;
      rs1_d  = rs1;
      rs2_d  = rs2;
    end else if (consume) begin
      vld_d = 1'b0;
    end else if (vld_q) begin
      // Stalled: keep held operands current with any write-back to their source.
      if (hit_a) a_d = wb_data;
      if (hit_b) b_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

  assign out_valid  = vld_q;
  assign A          = a_q;
  assign B          = b_q;
  assign ALUControl = ctrl_q;
  assign out_rd     = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [3:0]  alu_ctrl_in = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] A, B;
  logic [3:0]  ALUControl;
  logic [4:0]  out_rd;

  alu_operand_stage #(.DATA_W(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_ctrl_in(alu_ctrl_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
  } tup_t;

  // Reference model: architectural registers plus the one instruction in flight.
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  tup_t        m_held  = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0;
  logic        acc = 1'b0;
  tup_t        exp_q[$];
  tup_t        got_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] readv(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_held  = '0;
    m_rs1   = '0;
    m_rs2   = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Advance one clock: evaluate the rules on the current inputs, then take the edge.
  task automatic step();
    logic nv;
    tup_t nh;
    logic [4:0] n1, n2;
    nv = m_valid; nh = m_held; n1 = m_rs1; n2 = m_rs2;
    acc = 1'b0;
    if (!rst) begin
      if (m_valid && out_ready) exp_q.push_back(m_held);
      if (flush) nv = 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        acc = 1'b1;
        nv = 1'b1;
        nh.a = readv(rs1); nh.b = readv(rs2); nh.c = alu_ctrl_in; nh.rd = rd;
        n1 = rs1; n2 = rs2;
      end else if (m_valid && out_ready) nv = 1'b0;
      else if (m_valid) begin
        if (wb_en && m_rs1 != 0 && wb_addr == m_rs1) nh.a = wb_data;
        if (wb_en && m_rs2 != 0 && wb_addr == m_rs2) nh.b = wb_data;
      end
    end
    @(posedge clk);
    if (!rst) begin
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_valid = nv; m_held = nh; m_rs1 = n1; m_rs2 = n2;
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic [3:0] c);
    in_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; alu_ctrl_in = c;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("A", A, m_held.a);
        chk("B", B, m_held.b);
        chk("ALUControl", 32'(ALUControl), 32'(m_held.c));
        chk("out_rd", 32'(out_rd), 32'(m_held.rd));
      end
      if (out_valid && out_ready) got_q.push_back({A, B, ALUControl, out_rd});
    end
  end

  task automatic compare_streams(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({name, "_A"}, got_q[i].a, exp_q[i].a);
      chk({name, "_B"}, got_q[i].b, exp_q[i].b);
      chk({name, "_ctrl"}, 32'(got_q[i].c), 32'(exp_q[i].c));
      chk({name, "_rd"}, 32'(got_q[i].rd), 32'(exp_q[i].rd));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int n_acc;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Write/read: r3=0x10, r4=3, issue sub.
    wb(5'd3, 32'h0000_0010); step();
    wb(5'd4, 32'h0000_0003); step();
    wb_en = 1'b0; issue(5'd3, 5'd4, 5'd1, 4'b0110); step();
    chk("wr_valid", 32'(out_valid), 32'd1);
    chk("wr_A", A, 32'h10);
    chk("wr_B", B, 32'h3);
    chk("wr_ctrl", 32'(ALUControl), 32'h6);

    // Bypass into the read path, and r0 stays zero.
    wb(5'd7, 32'hDEAD_BEEF); issue(5'd7, 5'd0, 5'd2, 4'b0000); step();
    chk("byp_A", A, 32'hDEAD_BEEF);
    chk("byp_B", B, 32'h0);
    in_valid = 1'b0; wb(5'd0, 32'hFFFF_FFFF); step();
    wb_en = 1'b0; issue(5'd0, 5'd0, 5'd3, 4'b0010); step();
    chk("r0_A", A, 32'h0);
    chk("r0_B", B, 32'h0);

    // Stall refresh of both held operands.
    in_valid = 1'b0; wb(5'd9, 32'h1); step();
    wb_en = 1'b0; out_ready = 1'b0; issue(5'd9, 5'd9, 5'd12, 4'b0010); step();
    chk("stall_A0", A, 32'h1);
    in_valid = 1'b0; wb(5'd9, 32'h55); step();
    chk("refresh_A", A, 32'h55);
    chk("refresh_B", B, 32'h55);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_rd", 32'(out_rd), 32'd12);

    // Flush has priority over a simultaneous capture.
    wb_en = 1'b0; out_ready = 1'b1; flush = 1'b1; issue(5'd3, 5'd4, 5'd5, 4'b0001); step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    idle(); step();
    chk("flush_no_issue", 32'(out_valid), 32'd0);

    // Reset mid-transaction.
    wb(5'd5, 32'h0000_1234); step();
    wb_en = 1'b0; out_ready = 1'b0; issue(5'd5, 5'd3, 5'd6, 4'b0111); step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    exp_q.delete();
    got_q.delete();
    step();
    rst = 1'b0; idle();
    issue(5'd5, 5'd0, 5'd1, 4'b0010); step();
    chk("post_rst_r5", A, 32'h0);
    idle(); step();
    exp_q.delete();
    got_q.delete();

    // Streaming: exactly 10 instructions, random out_ready and write-back.
    n_acc = 0;
    issue(5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
    while (n_acc < 10) begin
      out_ready = 1'($urandom);
      wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      step();
      if (acc) begin
        n_acc++;
        if (n_acc < 10) issue(5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
        else in_valid = 1'b0;
      end
    end
    idle(); step(); step();
    chk("stream_received", 32'(got_q.size()), 32'd10);
    compare_streams("stream");

    // Long random run with flushes and protocol-respecting input hold.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0))
        issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 4'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      step();
      if (acc) in_valid = 1'b0;
    end
    idle(); step(); step();
    compare_streams("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch and issue stage that sits directly upstream of the 32-bit ALU. It holds the 32-entry architectural register file and reads two source registers per instruction. It registers the operands together with the 4-bit ALU control code and drives them to the ALU's A, B and ALUControl inputs through a valid/ready handshake. Write-back from later stages is bypassed into both the read path and any held (stalled) operand, so the ALU never sees a stale value.

## Interface
Parameters:
- DATA_W, 32, operand/register width
- NREG, 32, number of registers; register 0 is hard-wired zero
- AW, 5, register address width, log2(NREG)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decoded instruction presented
- in_ready  out  1  stage can accept an instruction this cycle
- rs1  in  AW  source register for A
- rs2  in  AW  source register for B
- rd  in  AW  destination tag, passed through
- alu_ctrl_in  in  4  ALU operation code (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt), passed through unchanged
- flush  in  1  discard the held instruction
- wb_en  in  1  register write enable
- wb_addr  in  AW  write register
- wb_data  in  DATA_W  write data
- out_valid  out  1  A/B/ALUControl/out_rd are valid
- out_ready  in  1  downstream consumes the issued instruction
- A  out  DATA_W  operand 1 to ALU
- B  out  DATA_W  operand 2 to ALU
- ALUControl  out  4  operation code to ALU
- out_rd  out  AW  destination tag accompanying the result

## Operation
Register file:
- NREG x DATA_W flops.
- Reads of register 0 return 0.
- Writes with wb_addr==0 are ignored.
- Write on the clk edge when wb_en=1.

Read bypass:
- If wb_en && wb_addr==rs1 && rs1!=0 in the capture cycle, A is captured from wb_data rather than the array.
- The same rule applies to rs2/B.

Issue register:
- Holds one instruction: A, B, ALUControl, out_rd, the captured rs1/rs2 tags and out_valid.
- in_ready = !out_valid || out_ready (combinational).
- Capture on in_valid && in_ready. The issue register loads the operands, alu_ctrl_in, rd, rs1, rs2, and out_valid<=1.
- Else, if out_valid && out_ready, then out_valid<=0. A/B/ALUControl/out_rd retain their values.

Held-operand refresh:
- Applies while out_valid=1 and the instruction is not consumed this cycle.
- If wb_en && wb_addr==held rs1 && held rs1!=0, then A<=wb_data. The same rule applies to B.
- Both refreshes can occur in the same cycle.

Flush:
- Forces out_valid<=0 at the next edge.
- Flush has priority over a simultaneous capture: no instruction is accepted that cycle, even though in_ready may read 1.
- The register file still writes during flush.

## Timing
- Reset clears all registers, including the register file, to 0: out_valid=0, A=0, B=0, ALUControl=0, out_rd=0, held tags=0.
- in_ready=1 immediately on reset.
- Reset asserted mid-transaction drops the held instruction with no partial output.
- Latency: an instruction accepted at edge N is presented with out_valid=1 in the cycle after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while out_ready=1. Back-to-back capture and consume in the same cycle replaces the held instruction.
- When out_ready=0 and out_valid=1: in_ready=0, and A/B/ALUControl/out_rd are stable except for the held-operand refresh.
- Write-back and read of the same register in one cycle: the read gets the new data (write-first).
- Two instructions are never merged or dropped; in_valid with in_ready=0 must be held by upstream.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, A=B=0, and in_ready=1 within the same cycle. After release, reading r5 gives A=0.
- Write/read: write r3=0x0000_0010 and r4=0x0000_0003, then issue rs1=3, rs2=4, ctrl=0110 -> one cycle later out_valid=1, A=0x10, B=3, ALUControl=0110.
- Bypass: in the same cycle, wb r7=0xDEAD_BEEF and issue rs1=7, rs2=0 -> A=0xDEADBEEF, B=0. Writing r0=0xFFFF_FFFF then reading r0 -> A=0.
- Stall refresh: hold out_ready=0 with the issued rs1=9, rs2=9 (r9=1), then wb r9=0x55 -> A=B=0x55 next cycle, in_ready=0, and out_rd unchanged.
- Flush priority: out_valid=1, out_ready=1, in_valid=1, flush=1 -> next cycle out_valid=0, and the new instruction is not issued.
- Streaming: 10 back-to-back instructions with random out_ready -> the ALU receives all 10 in order with correct operands, none duplicated or lost.
